// File: rtl/subservient_pkg.sv
// Shared definitions for the subservient SRAM arbiter and its helpers.
package subservient_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Which Wishbone master owns the current transaction.
  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_DBG  = 1'b1
  } gnt_e;

  // A 32-bit Wishbone word is moved through the 8-bit SRAM as four byte beats.
  localparam int BEATS  = 4;
  localparam int BEAT_W = $clog2(BEATS);

  // Byte lane 'idx' of a 32-bit word (lane 0 is the least significant byte).
  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [BEAT_W-1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/subservient_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the registered last-grant; the owner strobes i_update when a
// grant is finished so the other requester wins the next tie.
module subservient_rr_arb2 #(
  parameter logic RESET_LAST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_update_gnt,
  output logic       o_valid,
  output logic       o_gnt
);

  logic last_q;

  // Pick a requester; on a tie, the one that was not served last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    o_valid = |i_req;
    o_gnt   = 1'b0;
    case (i_req)
      2'b01:   o_gnt = 1'b0;
      2'b10:   o_gnt = 1'b1;
      2'b11:   o_gnt = ~last_q;
      default: o_gnt = 1'b0;
    endcase
  end

  // Remember who was served last.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge, independent of order.
    if (i_rst) begin
      last_q <= RESET_LAST;
    end else if (i_update) begin
      last_q <= i_update_gnt;
    end
  end

endmodule

// File: rtl/subservient_sram_arbiter.sv
// Shares the single-port 8-bit SRAM between the bit-serial register file and
// two 32-bit Wishbone masters (core and debug). The RF always wins a cycle it
// asks for; the Wishbone masters take turns per transaction and each word is
// moved as four byte beats.
module subservient_sram_arbiter
  import subservient_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // register file port
  input  logic [AW-1:0] i_rf_addr,
  input  logic [7:0]    i_rf_wdata,
  input  logic          i_rf_wen,
  input  logic          i_rf_ren,
  output logic [7:0]    o_rf_rdata,
  // core Wishbone
  input  logic [AW-1:0] i_wb_core_adr,
  input  logic [31:0]   i_wb_core_dat,
  input  logic [3:0]    i_wb_core_sel,
  input  logic          i_wb_core_we,
  input  logic          i_wb_core_cyc,
  output logic [31:0]   o_wb_core_rdt,
  output logic          o_wb_core_ack,
  // debug Wishbone
  input  logic [AW-1:0] i_wb_dbg_adr,
  input  logic [31:0]   i_wb_dbg_dat,
  input  logic [3:0]    i_wb_dbg_sel,
  input  logic          i_wb_dbg_we,
  input  logic          i_wb_dbg_cyc,
  output logic [31:0]   o_wb_dbg_rdt,
  output logic          o_wb_dbg_ack,
  // SRAM
  output logic [AW-1:0] o_sram_addr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e            state_q;
  logic [BEAT_W-1:0] beat_q;
  gnt_e              gnt_q;
  logic              core_ack_q;
  logic              dbg_ack_q;

  logic [31:0]       core_rdt_q;
  logic [31:0]       dbg_rdt_q;
  logic              rd_pend_q;
  logic [BEAT_W-1:0] rd_idx_q;
  gnt_e              rd_gnt_q;

  // Signals of the currently granted master.
  logic [AW-1:0]     g_adr;
  logic [31:0]       g_dat;
  logic [3:0]        g_sel;
  logic              g_we;
  logic              g_cyc;

  logic              rf_req;
  logic              wb_issue;
  logic              wb_abort;
  logic              arb_valid;
  logic              arb_gnt;
  logic              arb_update;
  logic [31:0]       core_rdt;
  logic [31:0]       dbg_rdt;

  // Word addresses only: the byte lane comes from the beat counter.
  logic              unused_adr_lsb;
  assign unused_adr_lsb = ^g_adr[1:0];

  assign rf_req     = i_rf_wen | i_rf_ren;
  assign wb_issue   = (state_q == ACCESS) && g_cyc && !rf_req;
  assign wb_abort   = (state_q == ACCESS) && !g_cyc;
  assign arb_update = (state_q == FINISH) || wb_abort;
  assign o_rf_rdata = i_sram_rdata;

  subservient_rr_arb2 #(
    .RESET_LAST (GNT_DBG)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        ({i_wb_dbg_cyc, i_wb_core_cyc}),
    .i_update     (arb_update),
    .i_update_gnt (gnt_q),
    .o_valid      (arb_valid),
    .o_gnt        (arb_gnt)
  );

  // Route the granted master's request signals.
  always_comb begin
    if (gnt_q == GNT_DBG) begin
      g_adr = i_wb_dbg_adr;
      g_dat = i_wb_dbg_dat;
      g_sel = i_wb_dbg_sel;
      g_we  = i_wb_dbg_we;
      g_cyc = i_wb_dbg_cyc;
    end else begin
      g_adr = i_wb_core_adr;
      g_dat = i_wb_core_dat;
      g_sel = i_wb_core_sel;
      g_we  = i_wb_core_we;
      g_cyc = i_wb_core_cyc;
    end
  end

  // SRAM port: RF first, otherwise the current Wishbone beat, else quiet.
  always_comb begin
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    o_sram_wen   = 1'b0;
    o_sram_ren   = 1'b0;
    if (!i_rst) begin
      if (rf_req) begin
        o_sram_addr  = i_rf_addr;
        o_sram_wdata = i_rf_wdata;
        o_sram_wen   = i_rf_wen;
        o_sram_ren   = i_rf_ren && !i_rf_wen;
      end else if (wb_issue) begin
        o_sram_addr  = {g_adr[AW-1:2], beat_q};
        o_sram_wdata = byte_of(g_dat, beat_q);
        o_sram_wen   = g_we && g_sel[beat_q];
        o_sram_ren   = !g_we;
      end
    end
  end

  // Sequencer: grant in IDLE, four beats in ACCESS, ack in FINISH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      gnt_q      <= GNT_CORE;
      core_ack_q <= 1'b0;
      dbg_ack_q  <= 1'b0;
    end else begin
      core_ack_q <= 1'b0;
      dbg_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q   <= gnt_e'(arb_gnt);
            beat_q  <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!g_cyc) begin
            state_q <= IDLE;
          end else if (!rf_req) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
              state_q    <= FINISH;
              core_ack_q <= (gnt_q == GNT_CORE);
              dbg_ack_q  <= (gnt_q == GNT_DBG);
            end
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data words: the byte returned this cycle is merged in so the full
  // word is visible in the ack cycle, before it lands in the register.
  always_comb begin
    core_rdt = core_rdt_q;
    dbg_rdt  = dbg_rdt_q;
    if (rd_pend_q) begin
      if (rd_gnt_q == GNT_CORE) core_rdt[8*rd_idx_q +: 8] = i_sram_rdata;
      else                      dbg_rdt[8*rd_idx_q +: 8]  = i_sram_rdata;
    end
  end

  // Track issued Wishbone read beats and capture their bytes a cycle later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: these word registers are reset (unlike a RAM array) because the
      // masters can see rdt at any time and must read zero after reset.
      core_rdt_q <= '0;
      dbg_rdt_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
      rd_gnt_q   <= GNT_CORE;
    end else begin
      rd_pend_q <= wb_issue && !g_we;
      rd_idx_q  <= beat_q;
      rd_gnt_q  <= gnt_q;
      if (rd_pend_q) begin
        if (rd_gnt_q == GNT_CORE) core_rdt_q <= core_rdt;
        else                      dbg_rdt_q  <= dbg_rdt;
      end
    end
  end

  assign o_wb_core_rdt = core_rdt;
  assign o_wb_dbg_rdt  = dbg_rdt;
  assign o_wb_core_ack = core_ack_q;
  assign o_wb_dbg_ack  = dbg_ack_q;

  // The RF should never read and write in one cycle; the write is kept.
  rf_single_op : assert property (@(posedge i_clk) disable iff (i_rst)
                                  !(i_rf_wen && i_rf_ren))
    else $warning("rf write and read in the same cycle, read dropped");

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Randomized scoreboard bench for subservient_sram_arbiter. A shadow byte
// array predicts every read; expectations are queued when a request is made
// and a negedge monitor pops them when the DUT acks.
module tb_subservient_sram_arbiter;

  localparam int AW = 9;
  localparam int TIMEOUT = 200;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [AW-1:0] i_rf_addr = '0;
  logic [7:0]    i_rf_wdata = '0;
  logic          i_rf_wen = 1'b0;
  logic          i_rf_ren = 1'b0;
  logic [7:0]    o_rf_rdata;
  logic [AW-1:0] i_wb_core_adr = '0;
  logic [31:0]   i_wb_core_dat = '0;
  logic [3:0]    i_wb_core_sel = '0;
  logic          i_wb_core_we = 1'b0;
  logic          i_wb_core_cyc = 1'b0;
  logic [31:0]   o_wb_core_rdt;
  logic          o_wb_core_ack;
  logic [AW-1:0] i_wb_dbg_adr = '0;
  logic [31:0]   i_wb_dbg_dat = '0;
  logic [3:0]    i_wb_dbg_sel = '0;
  logic          i_wb_dbg_we = 1'b0;
  logic          i_wb_dbg_cyc = 1'b0;
  logic [31:0]   o_wb_dbg_rdt;
  logic          o_wb_dbg_ack;
  logic [AW-1:0] o_sram_addr;
  logic [7:0]    o_sram_wdata;
  logic          o_sram_wen;
  logic          o_sram_ren;
  logic [7:0]    i_sram_rdata = '0;

  always #5 i_clk = ~i_clk;

  subservient_sram_arbiter #(.AW(AW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rf_addr     (i_rf_addr),
    .i_rf_wdata    (i_rf_wdata),
    .i_rf_wen      (i_rf_wen),
    .i_rf_ren      (i_rf_ren),
    .o_rf_rdata    (o_rf_rdata),
    .i_wb_core_adr (i_wb_core_adr),
    .i_wb_core_dat (i_wb_core_dat),
    .i_wb_core_sel (i_wb_core_sel),
    .i_wb_core_we  (i_wb_core_we),
    .i_wb_core_cyc (i_wb_core_cyc),
    .o_wb_core_rdt (o_wb_core_rdt),
    .o_wb_core_ack (o_wb_core_ack),
    .i_wb_dbg_adr  (i_wb_dbg_adr),
    .i_wb_dbg_dat  (i_wb_dbg_dat),
    .i_wb_dbg_sel  (i_wb_dbg_sel),
    .i_wb_dbg_we   (i_wb_dbg_we),
    .i_wb_dbg_cyc  (i_wb_dbg_cyc),
    .o_wb_dbg_rdt  (o_wb_dbg_rdt),
    .o_wb_dbg_ack  (o_wb_dbg_ack),
    .o_sram_addr   (o_sram_addr),
    .o_sram_wdata  (o_sram_wdata),
    .o_sram_wen    (o_sram_wen),
    .o_sram_ren    (o_sram_ren),
    .i_sram_rdata  (i_sram_rdata)
  );

  // SRAM model and the bench's own view of what it should hold.
  logic [7:0] mem    [0:2**AW-1];
  logic [7:0] shadow [0:2**AW-1];

  always @(posedge i_clk) begin
    if (o_sram_ren) i_sram_rdata <= mem[o_sram_addr];
    if (o_sram_wen) mem[o_sram_addr] = o_sram_wdata;
  end

  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  exp_t exp_core[$];
  exp_t exp_dbg[$];
  int   ack_order[$];
  int   ack_cnt[2] = '{0, 0};

  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Monitor: pops expectations on acks and checks RF read data one cycle on.
  exp_t e;
  logic rf_chk = 1'b0;
  logic [7:0] rf_exp = '0;
  always @(negedge i_clk) begin
    if (o_wb_core_ack) begin
      ack_cnt[0]++;
      ack_order.push_back(0);
      if (exp_core.size() == 0) begin
        total++; bad++;
        $display("FAIL core_unexpected_ack: actual=1 expected=0 (cycle %0d)", cyc_n);
      end else begin
        e = exp_core.pop_front();
        if (e.rd) check("core_rdt", o_wb_core_rdt, e.data);
      end
    end
    if (o_wb_dbg_ack) begin
      ack_cnt[1]++;
      ack_order.push_back(1);
      if (exp_dbg.size() == 0) begin
        total++; bad++;
        $display("FAIL dbg_unexpected_ack: actual=1 expected=0 (cycle %0d)", cyc_n);
      end else begin
        e = exp_dbg.pop_front();
        if (e.rd) check("dbg_rdt", o_wb_dbg_rdt, e.data);
      end
    end
    if (rf_chk) check("rf_rdata", {24'd0, o_rf_rdata}, {24'd0, rf_exp});
    rf_chk = i_rf_ren && !i_rf_wen && !i_rst;
    rf_exp = shadow[i_rf_addr];
  end

  task automatic drive_wb(input int m, input logic [AW-1:0] adr, input logic we,
                          input logic [3:0] sel, input logic [31:0] dat, input logic cyc);
    if (m == 0) begin
      i_wb_core_adr = adr; i_wb_core_dat = dat; i_wb_core_sel = sel;
      i_wb_core_we = we;   i_wb_core_cyc = cyc;
    end else begin
      i_wb_dbg_adr = adr;  i_wb_dbg_dat = dat;  i_wb_dbg_sel = sel;
      i_wb_dbg_we = we;    i_wb_dbg_cyc = cyc;
    end
  endtask

  // One complete Wishbone transaction; called just after a rising edge.
  // Returns the cycles from raising cyc to the ack.
  task automatic wb_txn(input int m, input logic [AW-1:0] adr, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat, output int lat);
    exp_t          x;
    logic [AW-1:0] base;
    int            issued;
    int            n;
    base   = {adr[AW-1:2], 2'b00};
    x.rd   = !we;
    x.data = '0;
    for (int b = 0; b < 4; b++) begin
      if (we) begin
        if (sel[b]) shadow[base + AW'(b)] = dat[8*b +: 8];
      end else begin
        x.data[8*b +: 8] = shadow[base + AW'(b)];
      end
    end
    if (m == 0) exp_core.push_back(x);
    else        exp_dbg.push_back(x);
    drive_wb(m, adr, we, sel, dat, 1'b1);
    issued = cyc_n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!((m == 0) ? o_wb_core_ack : o_wb_dbg_ack) && n < TIMEOUT);
    if (n >= TIMEOUT) begin
      total++; bad++;
      $display("FAIL wb_ack_timeout m=%0d: actual=no ack expected=ack within %0d", m, TIMEOUT);
    end
    lat = cyc_n - issued;
    @(posedge i_clk); #1;
    drive_wb(m, adr, we, sel, dat, 1'b0);
  endtask

  task automatic rand_txn(input int m);
    logic [AW-1:0] adr;
    int            lat;
    adr = {1'b0, m[0], 7'($urandom)};
    wb_txn(m, adr, 1'($urandom), 4'($urandom), $urandom, lat);
    repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst = 1'b0;
  endtask

  int   lat, lat_a, lat_b, lat_c, lat_d, cnt0;
  int   r;
  logic rf_run;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      mem[a]    = 8'($urandom);
      shadow[a] = mem[a];
    end

    // Reset state.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_core_ack", {31'd0, o_wb_core_ack}, 32'd0);
    check("rst_dbg_ack",  {31'd0, o_wb_dbg_ack},  32'd0);
    check("rst_sram_wen", {31'd0, o_sram_wen},    32'd0);
    check("rst_sram_ren", {31'd0, o_sram_ren},    32'd0);
    check("rst_core_rdt", o_wb_core_rdt, 32'd0);
    check("rst_dbg_rdt",  o_wb_dbg_rdt,  32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Core read, uncontended.
    for (int b = 0; b < 4; b++) begin
      mem[9'h010 + AW'(b)]    = 8'(8'h11 * (b + 1));
      shadow[9'h010 + AW'(b)] = 8'(8'h11 * (b + 1));
    end
    fork
      wb_txn(0, 9'h010, 1'b0, 4'hF, 32'd0, lat);
      begin
        @(negedge i_clk);
        check("rd_idle_no_ren", {31'd0, o_sram_ren}, 32'd0);
        for (int b = 0; b < 4; b++) begin
          @(negedge i_clk);
          check("rd_beat_addr", {23'd0, o_sram_addr}, 32'h10 + 32'(b));
          check("rd_beat_ren",  {31'd0, o_sram_ren},  32'd1);
        end
      end
    join
    check("core_rd_latency", 32'(lat), 32'd5);
    check("core_rdt_hold", o_wb_core_rdt, 32'h44332211);

    // Core write with partial byte enables.
    wb_txn(0, 9'h020, 1'b1, 4'b0101, 32'hAABBCCDD, lat);
    check("core_wr_latency", 32'(lat), 32'd5);
    check("wr_byte0", {24'd0, mem[9'h020]}, 32'hDD);
    check("wr_byte1", {24'd0, mem[9'h021]}, {24'd0, shadow[9'h021]});
    check("wr_byte2", {24'd0, mem[9'h022]}, 32'hBB);
    check("wr_byte3", {24'd0, mem[9'h023]}, {24'd0, shadow[9'h023]});

    // Debug read with the RF stealing two cycles.
    fork
      wb_txn(1, 9'h080, 1'b0, 4'hF, 32'd0, lat);
      begin
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rf_ren = 1'b1; i_rf_addr = 9'h100;
        @(negedge i_clk);
        check("steal_addr0", {23'd0, o_sram_addr}, 32'h100);
        @(posedge i_clk); #1;
        i_rf_addr = 9'h101;
        @(negedge i_clk);
        check("steal_addr1", {23'd0, o_sram_addr}, 32'h101);
        @(posedge i_clk); #1;
        i_rf_ren = 1'b0;
        @(negedge i_clk);
        check("steal_resume_addr", {23'd0, o_sram_addr}, 32'h081);
      end
    join
    check("dbg_steal_latency", 32'(lat), 32'd7);

    // Abort after two write beats.
    cnt0 = ack_cnt[0];
    drive_wb(0, 9'h040, 1'b1, 4'hF, 32'h01020304, 1'b1);
    repeat (3) begin @(posedge i_clk); #1; end
    drive_wb(0, 9'h040, 1'b1, 4'hF, 32'h01020304, 1'b0);
    shadow[9'h040] = 8'h04;
    shadow[9'h041] = 8'h03;
    repeat (8) begin @(posedge i_clk); #1; end
    check("abort_no_ack", 32'(ack_cnt[0]), 32'(cnt0));
    check("abort_byte0", {24'd0, mem[9'h040]}, 32'h04);
    check("abort_byte1", {24'd0, mem[9'h041]}, 32'h03);
    check("abort_byte2", {24'd0, mem[9'h042]}, {24'd0, shadow[9'h042]});
    check("abort_byte3", {24'd0, mem[9'h043]}, {24'd0, shadow[9'h043]});

    // Reset in the middle of a debug read.
    cnt0 = ack_cnt[1];
    drive_wb(1, 9'h090, 1'b0, 4'hF, 32'd0, 1'b1);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst_ren", {31'd0, o_sram_ren}, 32'd0);
    check("midrst_wen", {31'd0, o_sram_wen}, 32'd0);
    check("midrst_dbg_rdt", o_wb_dbg_rdt, 32'd0);
    @(posedge i_clk); #1;
    drive_wb(1, 9'h090, 1'b0, 4'hF, 32'd0, 1'b0);
    repeat (8) begin @(posedge i_clk); #1; end
    check("midrst_no_ack", 32'(ack_cnt[1]), 32'(cnt0));

    // Contention from reset: core first, then strict alternation.
    do_reset();
    ack_order.delete();
    fork
      begin
        wb_txn(0, 9'h004, 1'b0, 4'hF, 32'd0, lat_a);
        wb_txn(0, 9'h008, 1'b0, 4'hF, 32'd0, lat_c);
      end
      begin
        wb_txn(1, 9'h084, 1'b0, 4'hF, 32'd0, lat_b);
        wb_txn(1, 9'h088, 1'b0, 4'hF, 32'd0, lat_d);
      end
    join
    check("cont_core_first_lat", 32'(lat_a), 32'd5);
    check("cont_dbg_wait_lat",   32'(lat_b), 32'd11);
    check("cont_core_again_lat", 32'(lat_c), 32'd11);
    check("cont_ack_count", 32'(ack_order.size()), 32'd4);
    for (int i = 0; i < ack_order.size(); i++)
      check("cont_ack_order", 32'(ack_order[i]), 32'(i % 2));

    // RF write and read together: the write wins.
    i_rf_wen = 1'b1; i_rf_ren = 1'b1; i_rf_addr = 9'h150; i_rf_wdata = 8'h5A;
    shadow[9'h150] = 8'h5A;
    @(negedge i_clk);
    check("coll_wen", {31'd0, o_sram_wen}, 32'd1);
    check("coll_ren", {31'd0, o_sram_ren}, 32'd0);
    @(posedge i_clk); #1;
    i_rf_wen = 1'b0; i_rf_ren = 1'b0;
    @(negedge i_clk);
    check("coll_mem", {24'd0, mem[9'h150]}, 32'h5A);
    @(posedge i_clk); #1;

    // Random traffic: core in 0x000-0x07F, debug in 0x080-0x0FF, RF above.
    rf_run = 1'b1;
    fork
      begin
        while (rf_run) begin
          r          = $urandom_range(0, 99);
          i_rf_addr  = {1'b1, 8'($urandom)};
          i_rf_wdata = 8'($urandom);
          i_rf_ren   = (r < 25);
          i_rf_wen   = (r >= 25) && (r < 40);
          if (i_rf_wen) shadow[i_rf_addr] = i_rf_wdata;
          @(posedge i_clk); #1;
        end
        i_rf_ren = 1'b0;
        i_rf_wen = 1'b0;
      end
      begin
        fork
          for (int k = 0; k < 60; k++) rand_txn(0);
          for (int k = 0; k < 60; k++) rand_txn(1);
        join
        rf_run = 1'b0;
      end
    join
    repeat (4) begin @(posedge i_clk); #1; end
    check("exp_core_drained", 32'(exp_core.size()), 32'd0);
    check("exp_dbg_drained",  32'(exp_dbg.size()),  32'd0);
    for (int a = 0; a < 2**AW; a++)
      check("mem_final", {24'd0, mem[a]}, {24'd0, shadow[a]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
